// File: rtl/fetch_sequencer_pkg.sv
// Shared encodings for the fetch sequencer: FSM states, opcode length field and length codes.
package fetch_sequencer_pkg;

    localparam int DATA_W      = 8;
    localparam int MAX_BYTES   = 3;
    localparam int OPC_LEN_MSB = DATA_W - 1;
    localparam int OPC_LEN_LSB = DATA_W - 2;

    typedef enum logic [2:0] {
        FS_IDLE  = 3'd0,
        FS_FETCH = 3'd1,
        FS_DONE  = 3'd2,
        FS_JMP_L = 3'd3,
        FS_JMP_H = 3'd4
    } fs_state_e;

    localparam logic [1:0] LEN_1   = 2'b00;
    localparam logic [1:0] LEN_2   = 2'b01;
    localparam logic [1:0] LEN_3   = 2'b10;
    localparam logic [1:0] LEN_RSV = 2'b11;

    // Index of the final byte slot for a given opcode length code; reserved codes fetch one byte.
    function automatic logic [1:0] last_idx(input logic [1:0] len_code);
        case (len_code)
            LEN_2:   last_idx = 2'd1;
            LEN_3:   last_idx = 2'd2;
            default: last_idx = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/fetch_sequencer_instr_buffer.sv
// Opcode plus two operand byte registers, written one slot at a time by the fetch sequencer.
module fetch_sequencer_instr_buffer
    import fetch_sequencer_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_we,
    input  logic [1:0]            i_idx,
    input  logic [DATA_W-1:0]     i_data,
    output logic [DATA_W-1:0]     o_opcode,
    output logic [2*DATA_W-1:0]   o_operand
);

    logic [DATA_W-1:0] r_opcode;
    logic [DATA_W-1:0] r_byte1;
    logic [DATA_W-1:0] r_byte2;

    // Opcode writes clear both operand bytes so short instructions read zero in unfetched slots.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_opcode <= '0;
            r_byte1  <= '0;
            r_byte2  <= '0;
        end else if (i_we) begin
            case (i_idx)
                2'd0: begin
                    r_opcode <= i_data;
                    r_byte1  <= '0;
                    r_byte2  <= '0;
                end
                2'd1:    r_byte1 <= i_data;
                2'd2:    r_byte2 <= i_data;
                default: ;
            endcase
        end
    end

    assign o_opcode  = r_opcode;
    assign o_operand = {r_byte2, r_byte1};

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/jump control stage driving the PC strobes and assembling 1-3 byte instructions for the decoder.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_run,
    input  logic [DATA_W-1:0]     i_mem_data,
    input  logic                  i_mem_ready,
    output logic                  o_mem_rd,
    output logic                  o_pc_cs,
    output logic                  o_pc_oe_a,
    output logic                  o_pc_cnt_en,
    output logic                  o_pc_we_l,
    output logic                  o_pc_we_h,
    output logic [DATA_W-1:0]     o_bus_out,
    output logic                  o_bus_oe,
    output logic [DATA_W-1:0]     o_opcode,
    output logic [2*DATA_W-1:0]   o_operand,
    output logic                  o_instr_valid,
    input  logic                  i_instr_ack,
    input  logic                  i_jump_req,
    input  logic [DATA_W-1:0]     i_jump_lo,
    input  logic [DATA_W-1:0]     i_jump_hi
);

    fs_state_e         r_state;
    fs_state_e         w_state_nxt;
    logic [1:0]        r_idx;
    logic [1:0]        w_idx_nxt;
    logic [1:0]        r_last_idx;
    logic [1:0]        w_last_idx;
    logic              w_capture;
    logic              w_last_byte;
    logic              w_jump_take;
    logic [DATA_W-1:0] r_jump_lo;
    logic [DATA_W-1:0] r_jump_hi;

    // While the opcode is on the bus its length comes straight from mem_data, afterwards from the register.
    assign w_capture   = (r_state == FS_FETCH) && i_mem_ready;
    assign w_last_idx  = (r_idx == 2'd0) ? last_idx(i_mem_data[OPC_LEN_MSB:OPC_LEN_LSB]) : r_last_idx;
    assign w_last_byte = (r_idx == w_last_idx);
    assign w_jump_take = (r_state == FS_DONE) && i_instr_ack && i_jump_req;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= FS_IDLE;
            r_idx      <= 2'd0;
            r_last_idx <= 2'd0;
            r_jump_lo  <= '0;
            r_jump_hi  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            if (w_capture && (r_idx == 2'd0)) begin
                r_last_idx <= w_last_idx;
            end
            if (w_jump_take) begin
                r_jump_lo <= i_jump_lo;
                r_jump_hi <= i_jump_hi;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        o_mem_rd      = 1'b0;
        o_pc_cs       = 1'b0;
        o_pc_oe_a     = 1'b0;
        o_pc_cnt_en   = 1'b0;
        o_pc_we_l     = 1'b0;
        o_pc_we_h     = 1'b0;
        o_bus_out     = '0;
        o_bus_oe      = 1'b0;
        o_instr_valid = 1'b0;
        case (r_state)
            FS_IDLE: begin
                w_idx_nxt = 2'd0;
                if (i_run) w_state_nxt = FS_FETCH;
            end
            FS_FETCH: begin
                o_pc_cs     = 1'b1;
                o_pc_oe_a   = 1'b1;
                o_mem_rd    = 1'b1;
                o_pc_cnt_en = i_mem_ready;
                if (i_mem_ready) begin
                    if (w_last_byte) begin
                        w_state_nxt = FS_DONE;
                        w_idx_nxt   = 2'd0;
                    end else begin
                        w_idx_nxt = r_idx + 2'd1;
                    end
                end
            end
            FS_DONE: begin
                o_instr_valid = 1'b1;
                if (i_instr_ack) begin
                    if (i_jump_req)  w_state_nxt = FS_JMP_L;
                    else if (i_run)  w_state_nxt = FS_FETCH;
                    else             w_state_nxt = FS_IDLE;
                end
            end
            FS_JMP_L: begin
                o_pc_cs     = 1'b1;
                o_pc_we_l   = 1'b1;
                o_bus_oe    = 1'b1;
                o_bus_out   = r_jump_lo;
                w_state_nxt = FS_JMP_H;
            end
            FS_JMP_H: begin
                o_pc_cs     = 1'b1;
                o_pc_we_h   = 1'b1;
                o_bus_oe    = 1'b1;
                o_bus_out   = r_jump_hi;
                w_state_nxt = i_run ? FS_FETCH : FS_IDLE;
            end
            default: w_state_nxt = FS_IDLE;
        endcase
    end

    fetch_sequencer_instr_buffer u_instr_buffer (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_we      (w_capture),
        .i_idx     (r_idx),
        .i_data    (i_mem_data),
        .o_opcode  (o_opcode),
        .o_operand (o_operand)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a small PC model and invariant monitors.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        run;
    logic [7:0]  mem_data;
    logic        mem_ready;
    logic        mem_rd, pc_cs, pc_oe_a, pc_cnt_en, pc_we_l, pc_we_h;
    logic [7:0]  bus_out;
    logic        bus_oe;
    logic [7:0]  opcode;
    logic [15:0] operand;
    logic        instr_valid;
    logic        instr_ack, jump_req;
    logic [7:0]  jump_lo, jump_hi;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt_pulses = 0;
    int viol_excl = 0;
    int viol_wait = 0;
    int viol_bus  = 0;
    logic [15:0] pc_model = 16'h0000;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .i_clk         (clk),
        .i_reset       (reset_n),
        .i_run         (run),
        .i_mem_data    (mem_data),
        .i_mem_ready   (mem_ready),
        .o_mem_rd      (mem_rd),
        .o_pc_cs       (pc_cs),
        .o_pc_oe_a     (pc_oe_a),
        .o_pc_cnt_en   (pc_cnt_en),
        .o_pc_we_l     (pc_we_l),
        .o_pc_we_h     (pc_we_h),
        .o_bus_out     (bus_out),
        .o_bus_oe      (bus_oe),
        .o_opcode      (opcode),
        .o_operand     (operand),
        .o_instr_valid (instr_valid),
        .i_instr_ack   (instr_ack),
        .i_jump_req    (jump_req),
        .i_jump_lo     (jump_lo),
        .i_jump_hi     (jump_hi)
    );

    wire [39:0] all_out = {mem_rd, pc_cs, pc_oe_a, pc_cnt_en, pc_we_l, pc_we_h,
                           bus_out, bus_oe, opcode, operand, instr_valid};

    // Inputs change just after posedge, so the negedge sees what the next posedge will act on.
    always @(negedge clk) begin
        if (pc_cnt_en) cnt_pulses++;
        if (32'(pc_cnt_en) + 32'(pc_we_l) + 32'(pc_we_h) > 1) viol_excl++;
        if (pc_cnt_en && !mem_ready) viol_wait++;
        if ((bus_oe && mem_rd) || (bus_oe && !(pc_we_l || pc_we_h))) viol_bus++;
        if (reset_n) begin
            if (pc_cnt_en) pc_model = pc_model + 16'h1;
            if (pc_we_l)   pc_model[7:0]  = bus_out;
            if (pc_we_h)   pc_model[15:8] = bus_out;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int bad;
        bit reached;
        logic [7:0] bytes3 [3];
        bytes3[0] = 8'h83; bytes3[1] = 8'h34; bytes3[2] = 8'h12;

        reset_n = 1'b0; run = 1'b0; mem_data = 8'h00; mem_ready = 1'b0;
        instr_ack = 1'b0; jump_req = 1'b0; jump_lo = 8'h00; jump_hi = 8'h00;
        #2;
        chk("reset_outputs", 64'(all_out), 64'h0);
        step(); step();
        reset_n = 1'b1;
        step();
        #1;
        chk("idle_no_rd", 64'(mem_rd), 64'h0);

        // 1-byte fetch
        run = 1'b1;
        step();
        cnt_pulses = 0;
        mem_data = 8'h05; mem_ready = 1'b1;
        #1;
        chk("f1_cnt_en", 64'(pc_cnt_en), 64'h1);
        chk("f1_mem_rd", 64'(mem_rd), 64'h1);
        step();
        mem_ready = 1'b0; run = 1'b0;
        #1;
        chk("f1_valid", 64'(instr_valid), 64'h1);
        chk("f1_opcode", 64'(opcode), 64'h05);
        chk("f1_operand", 64'(operand), 64'h0000);
        chk("f1_pulses", 64'(cnt_pulses), 64'h1);
        chk("f1_cs_low", 64'(pc_cs), 64'h0);
        instr_ack = 1'b1;
        step();
        instr_ack = 1'b0;
        #1;
        chk("f1_ack_drop", 64'(instr_valid), 64'h0);

        // 3-byte fetch with two wait cycles per byte
        run = 1'b1;
        step();
        run = 1'b0;
        cnt_pulses = 0;
        for (int b = 0; b < 3; b++) begin
            mem_ready = 1'b0;
            step(); step();
            mem_data = bytes3[b]; mem_ready = 1'b1;
            step();
        end
        mem_ready = 1'b0;
        #1;
        chk("f3_valid", 64'(instr_valid), 64'h1);
        chk("f3_opcode", 64'(opcode), 64'h83);
        chk("f3_operand", 64'(operand), 64'h1234);
        chk("f3_pulses", 64'(cnt_pulses), 64'h3);
        chk("f3_wait_cnt", 64'(viol_wait), 64'h0);

        // Jump to 0x4000; jump inputs change after ack to prove they were captured
        instr_ack = 1'b1; jump_req = 1'b1; jump_lo = 8'h00; jump_hi = 8'h40;
        step();
        instr_ack = 1'b0; jump_req = 1'b0; jump_lo = 8'hAA; jump_hi = 8'hBB;
        #1;
        chk("jl_we_l", 64'(pc_we_l), 64'h1);
        chk("jl_bus_out", 64'(bus_out), 64'h00);
        chk("jl_bus_oe", 64'(bus_oe), 64'h1);
        chk("jl_mem_rd", 64'(mem_rd), 64'h0);
        step();
        chk("jh_we_h", 64'(pc_we_h), 64'h1);
        chk("jh_bus_out", 64'(bus_out), 64'h40);
        step();
        chk("jmp_pc", 64'(pc_model), 64'h4000);
        chk("jmp_bus_off", 64'(bus_oe), 64'h0);

        // Hold without ack; jump_req alone must be ignored
        run = 1'b1;
        step();
        mem_data = 8'hC7; mem_ready = 1'b1;
        step();
        mem_ready = 1'b0; run = 1'b0; jump_req = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (!(instr_valid === 1'b1 && opcode === 8'hC7 && pc_cs === 1'b0)) bad++;
        end
        chk("hold_stable", 64'(bad), 64'h0);
        chk("hold_operand_clr", 64'(operand), 64'h0000);
        jump_req = 1'b0; instr_ack = 1'b1;
        step();
        instr_ack = 1'b0;
        #1;
        chk("hold_no_jump", 64'(pc_we_l), 64'h0);
        chk("hold_idle", 64'(mem_rd), 64'h0);

        // run drops mid 2-byte instruction
        run = 1'b1;
        step();
        mem_data = 8'h42; mem_ready = 1'b1;
        step();
        run = 1'b0; mem_ready = 1'b0;
        step();
        mem_data = 8'h99; mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        #1;
        chk("rd_valid", 64'(instr_valid), 64'h1);
        chk("rd_opcode", 64'(opcode), 64'h42);
        chk("rd_operand", 64'(operand), 64'h0099);
        instr_ack = 1'b1;
        step();
        instr_ack = 1'b0;
        step();
        chk("rd_idle_rd", 64'(mem_rd), 64'h0);
        chk("rd_idle_valid", 64'(instr_valid), 64'h0);

        // Random traffic for the invariant monitors
        for (int i = 0; i < 10000; i++) begin
            run       = ($urandom_range(0, 7) != 0);
            mem_ready = $urandom_range(0, 1);
            mem_data  = 8'($urandom);
            instr_ack = $urandom_range(0, 1);
            jump_req  = $urandom_range(0, 1);
            jump_lo   = 8'($urandom);
            jump_hi   = 8'($urandom);
            step();
        end
        chk("rand_excl", 64'(viol_excl), 64'h0);
        chk("rand_wait", 64'(viol_wait), 64'h0);
        chk("rand_bus", 64'(viol_bus), 64'h0);

        // Reset in the middle of a fetch
        run = 1'b1; instr_ack = 1'b1; jump_req = 1'b0; mem_ready = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            #1;
            if (mem_rd) reached = 1'b1;
            else step();
        end
        chk("reach_fetch", 64'(reached), 64'h1);
        instr_ack = 1'b0;
        mem_data = 8'h80; mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_reset_out", 64'(all_out), 64'h0);
        step();
        run = 1'b0;
        reset_n = 1'b1;
        step();
        #1;
        chk("post_reset_rd", 64'(mem_rd), 64'h0);
        chk("post_reset_valid", 64'(instr_valid), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
